// File: rtl/fwd_hazard_unit_pkg.sv
// rtl/fwd_hazard_unit_pkg.sv - shared encodings and scoreboard types for the forwarding/hazard unit
//
// Purpose : operand-mux select encodings, the register-zero constant, the
//           scoreboard entry type and the hit test shared by the comparators.
// Ports   : none (package).

package fwd_hazard_unit_pkg;

  // EX operand-mux select encodings
  localparam logic [1:0] SEL_RF    = 2'b00;  // register file value
  localparam logic [1:0] SEL_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] SEL_MEMWB = 2'b10;  // MEM/WB write-back data
  localparam logic [1:0] SEL_IMM   = 2'b11;  // immediate (operand B only)

  localparam logic [4:0]  REG_ZERO      = 5'd0;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  // Scoreboard slots: 0 = EX, 1 = MEM, 2 = WB
  localparam int SB_DEPTH = 3;
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

  typedef sb_entry_t [SB_DEPTH-1:0] sb_t;

  // True when entry e produces the value a reader of src needs.
  // r0 is hardwired, so a write to it never creates a dependency.
  function automatic logic entry_hits(input sb_entry_t e,
                                      input logic [4:0] src,
                                      input logic       uses);
    return e.valid && e.reg_write && (e.rd != REG_ZERO) && (e.rd == src) && uses;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - per-operand dependency comparator
//
// Purpose : compares one ID source register against the EX and MEM
//           scoreboard entries and produces the forward select the
//           operand will need once the instruction reaches EX.
// Ports   : ex_entry, mem_entry - scoreboard entries in EX and MEM
//           src, uses           - source register and its read flag
//           sel                 - SEL_RF / SEL_EXMEM / SEL_MEMWB
//           ex_load_hit         - the EX entry is a load producing src

import fwd_hazard_unit_pkg::*;

module fwd_match (
  input  sb_entry_t  ex_entry,
  input  sb_entry_t  mem_entry,
  input  logic [4:0] src,
  input  logic       uses,
  output logic [1:0] sel,
  output logic       ex_load_hit
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit      = entry_hits(ex_entry, src, uses);
    mem_hit     = entry_hits(mem_entry, src, uses);
    ex_load_hit = ex_hit && ex_entry.mem_read;

    // The EX entry is younger, so its value supersedes the MEM one.
    sel = SEL_RF;
    if (ex_hit) begin
      sel = SEL_EXMEM;
    end else if (mem_hit) begin
      sel = SEL_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding and load-use hazard unit
//
// Purpose : tracks the EX/MEM/WB destinations in a 3-entry scoreboard,
//           computes the EX operand-mux selects for the ID instruction and
//           registers them as it advances, detects load-use hazards and
//           counts stall cycles.
// Ports   : clk, rst_n                  - clock, async active-low reset
//           id_valid                    - ID holds a real instruction
//           id_rs/id_rt, id_uses_rs/rt  - ID sources and their read flags
//           id_rd, id_reg_write         - ID destination and write enable
//           id_mem_read                 - ID instruction is a load
//           id_use_imm                  - operand B is the immediate
//           ex_flush                    - squash the ID instruction
//           fwd_a_sel, fwd_b_sel        - registered EX operand selects
//           stall                       - hold PC and IF/ID, bubble into EX
//           stall_count                 - saturating stall-cycle count

import fwd_hazard_unit_pkg::*;

module fwd_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_use_imm,
  input  logic        ex_flush,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        stall,
  output logic [15:0] stall_count
);

  sb_t         sb_q, sb_d;
  logic [1:0]  fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0]  fwd_b_sel_q, fwd_b_sel_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic [1:0]  rs_sel, rt_sel;
  logic        rs_load_hit, rt_load_hit;
  logic        id_advance;
  sb_entry_t   ex_new;

  fwd_match u_match_rs (
    .ex_entry    (sb_q[SB_EX]),
    .mem_entry   (sb_q[SB_MEM]),
    .src         (id_rs),
    .uses        (id_uses_rs),
    .sel         (rs_sel),
    .ex_load_hit (rs_load_hit)
  );

  fwd_match u_match_rt (
    .ex_entry    (sb_q[SB_EX]),
    .mem_entry   (sb_q[SB_MEM]),
    .src         (id_rt),
    .uses        (id_uses_rt),
    .sel         (rt_sel),
    .ex_load_hit (rt_load_hit)
  );

  always_comb begin
    // A load in EX cannot forward until MEM, so its reader waits one cycle.
    // A flush kills the reader, which makes the stall pointless.
    stall      = id_valid && !ex_flush && (rs_load_hit || rt_load_hit);
    id_advance = id_valid && !stall && !ex_flush;

    ex_new           = '0;
    ex_new.valid     = 1'b1;
    ex_new.rd        = id_rd;
    ex_new.reg_write = id_reg_write;
    ex_new.mem_read  = id_mem_read;

    // Every entry ages one slot per clock; slot 0 takes the ID instruction
    // or a bubble.
    sb_d        = sb_q << SB_ENTRY_W;
    sb_d[SB_EX] = id_advance ? ex_new : '0;

    fwd_a_sel_d = SEL_RF;
    fwd_b_sel_d = SEL_RF;
    if (id_advance) begin
      fwd_a_sel_d = rs_sel;
      fwd_b_sel_d = id_use_imm ? SEL_IMM : rt_sel;
    end

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != STALL_CNT_MAX)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q          <= '0;
      fwd_a_sel_q   <= SEL_RF;
      fwd_b_sel_q   <= SEL_RF;
      stall_count_q <= '0;
    end else begin
      sb_q          <= sb_d;
      fwd_a_sel_q   <= fwd_a_sel_d;
      fwd_b_sel_q   <= fwd_b_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_a_sel   = fwd_a_sel_q;
  assign fwd_b_sel   = fwd_b_sel_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit

module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_use_imm;
  logic        ex_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall;
  logic [15:0] stall_count;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_use_imm   (id_use_imm),
    .ex_flush     (ex_flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the instructions that have left ID, youngest first.
  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } instr_t;

  instr_t pipe[3];
  int     m_a, m_b, m_cnt;
  int     n_cmp, n_bad;
  bit     stall_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit produces(input instr_t e, input int r);
    return e.v && e.wr && (e.rd != 0) && (e.rd == r);
  endfunction

  // Where the operand value will come from when this instruction sits in EX.
  function automatic int need_from(input int r, input bit uses);
    if (!uses || r == 0) return 0;
    if (produces(pipe[0], r)) return 1;
    if (produces(pipe[1], r)) return 2;
    return 0;
  endfunction

  function automatic bit model_stall();
    if (!id_valid || ex_flush || !pipe[0].ld) return 1'b0;
    return (id_uses_rs && produces(pipe[0], int'(id_rs))) ||
           (id_uses_rt && produces(pipe[0], int'(id_rt)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, rd: 0, wr: 0, ld: 0};
    m_a = 0;
    m_b = 0;
    m_cnt = 0;
  endtask

  task automatic model_clock(input bit s);
    bit     adv;
    instr_t nxt;
    adv = id_valid && !s && !ex_flush;
    if (adv) begin
      m_a = need_from(int'(id_rs), id_uses_rs);
      m_b = id_use_imm ? 3 : need_from(int'(id_rt), id_uses_rt);
      nxt = '{v: 1, rd: int'(id_rd), wr: id_reg_write, ld: id_mem_read};
    end else begin
      m_a = 0;
      m_b = 0;
      nxt = '{v: 0, rd: 0, wr: 0, ld: 0};
    end
    if (s && m_cnt < 65535) m_cnt++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nxt;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    bit s;
    #1;
    s = model_stall();
    stall_seen = stall;
    chk("stall", {31'b0, stall}, {31'b0, s});
    @(posedge clk);
    model_clock(s);
    #1;
    chk("fwd_a_sel", {30'b0, fwd_a_sel}, m_a);
    chk("fwd_b_sel", {30'b0, fwd_b_sel}, m_b);
    chk("stall_count", {16'b0, stall_count}, m_cnt);
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input int rd, input bit wr, input bit ld, input bit imm, input bit fl);
    id_valid     = v;
    id_rs        = 5'(rs);
    id_uses_rs   = urs;
    id_rt        = 5'(rt);
    id_uses_rt   = urt;
    id_rd        = 5'(rd);
    id_reg_write = wr;
    id_mem_read  = ld;
    id_use_imm   = imm;
    ex_flush     = fl;
  endtask

  task automatic set_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int extra;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_a", {30'b0, fwd_a_sel}, 0);
    chk("rst_b", {30'b0, fwd_b_sel}, 0);
    chk("rst_cnt", {16'b0, stall_count}, 0);
    rst_n = 1'b1;

    // Back-to-back: add r3 <- r1,r2 ; reader of r3
    set_id(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); tick();
    set_id(1, 3, 1, 0, 0, 8, 1, 0, 0, 0); tick();
    chk("b2b_a", {30'b0, fwd_a_sel}, 1);
    chk("b2b_nostall", {31'b0, stall_seen}, 0);

    // Distance 2: writer r5, unrelated, reader rt=r5
    set_id(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); tick();
    set_id(1, 1, 1, 2, 1, 9, 1, 0, 0, 0); tick();
    set_id(1, 1, 1, 5, 1, 10, 1, 0, 0, 0); tick();
    chk("dist2_b", {30'b0, fwd_b_sel}, 2);

    // Load-use: lw r7 ; reader rs=r7 held in ID while stalled
    set_id(1, 1, 1, 0, 0, 7, 1, 1, 1, 0); tick();
    set_id(1, 7, 1, 0, 0, 11, 1, 0, 0, 0); tick();
    chk("lu_stall", {31'b0, stall_seen}, 1);
    chk("lu_bubble_a", {30'b0, fwd_a_sel}, 0);
    tick();
    chk("lu_second_nostall", {31'b0, stall_seen}, 0);
    chk("lu_a", {30'b0, fwd_a_sel}, 2);
    chk("lu_cnt", {16'b0, stall_count}, 1);

    // Double writer of r4, then reader; then r0 writer and reader
    set_id(1, 1, 1, 2, 1, 4, 1, 0, 0, 0); tick();
    set_id(1, 1, 1, 2, 1, 4, 1, 0, 0, 0); tick();
    set_id(1, 4, 1, 0, 0, 12, 1, 0, 0, 0); tick();
    chk("dbl_a", {30'b0, fwd_a_sel}, 1);
    set_id(1, 1, 1, 2, 1, 0, 1, 0, 0, 0); tick();
    set_id(1, 0, 1, 0, 1, 13, 1, 0, 0, 0); tick();
    chk("r0_a", {30'b0, fwd_a_sel}, 0);
    chk("r0_b", {30'b0, fwd_b_sel}, 0);

    // Immediate overrides a real rt match
    set_id(1, 1, 1, 2, 1, 14, 1, 0, 0, 0); tick();
    set_id(1, 0, 0, 14, 1, 15, 1, 0, 1, 0); tick();
    chk("imm_b", {30'b0, fwd_b_sel}, 3);

    // Flush beats stall: lw r2 in EX, reader of r2 squashed
    set_id(1, 1, 1, 0, 0, 2, 1, 1, 1, 0); tick();
    set_id(1, 2, 1, 0, 0, 16, 1, 0, 0, 1); tick();
    chk("fl_nostall", {31'b0, stall_seen}, 0);
    chk("fl_a", {30'b0, fwd_a_sel}, 0);
    chk("fl_cnt", {16'b0, stall_count}, 1);

    // Reset asserted mid-stall clears everything immediately
    set_id(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); tick();
    set_id(1, 3, 1, 0, 0, 7, 1, 1, 1, 0); tick();
    chk("rs_pre_a", {30'b0, fwd_a_sel}, 1);
    set_id(1, 7, 1, 0, 0, 17, 1, 0, 0, 0);
    #2;
    chk("rs_pre_stall", {31'b0, stall}, 1);
    rst_n = 1'b0;
    #1;
    chk("rs_async_stall", {31'b0, stall}, 0);
    chk("rs_async_a", {30'b0, fwd_a_sel}, 0);
    chk("rs_async_b", {30'b0, fwd_b_sel}, 0);
    chk("rs_async_cnt", {16'b0, stall_count}, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rs_first_nostall", {31'b0, stall_seen}, 0);

    // Randomized traffic over a small register window to force matches
    for (int i = 0; i < 3000; i++) begin
      set_id($urandom_range(3) != 0, $urandom_range(7), $urandom_range(1), $urandom_range(7),
             $urandom_range(1), $urandom_range(7), $urandom_range(1), $urandom_range(2) == 0,
             $urandom_range(3) == 0, $urandom_range(7) == 0);
      tick();
    end

    // Saturation: a self-dependent load stalls every other cycle
    set_id(1, 7, 1, 0, 0, 7, 1, 1, 0, 0);
    extra = 0;
    for (int i = 0; i < 140000 && extra < 4; i++) begin
      tick();
      if (m_cnt == 65535) extra++;
    end
    chk("sat_reached", extra, 4);
    chk("sat_cnt", {16'b0, stall_count}, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
